// File: rtl/demux2to4_seq.sv
// demux2to4_seq: registered 1-to-2 demux of a 2-bit pair into two
// per-port FIFOs with valid/ready, X-select trapping and counters.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake
//   s0, in0, in1          route select and payload pair
//   a_valid/a_ready       port A handshake, out0/out1 head
//   b_valid/b_ready       port B handshake, out2/out3 head
//   sel_err               pulse after a word dropped for X/Z s0
//   a_cnt/b_cnt/err_cnt   saturating word counters

module demux2to4_seq_fifo #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [1:0] din_i,
  input  logic       rdy_i,
  output logic       vld_o,
  output logic [1:0] dout_o,
  output logic       full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic [1:0]    last_q;
  logic          pop;

  assign vld_o  = (cnt_q != '0);
  assign full_o = (cnt_q == (AW+1)'(DEPTH));
  assign pop    = vld_o & rdy_i;

  // An empty port keeps showing the last word it handed out.
  assign dout_o = vld_o ? mem_q[rd_q] : last_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_i, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) begin
        last_q <= mem_q[rd_q];
        rd_q   <= rd_q + 1'b1;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

module demux2to4_seq #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s0,
  input  logic             in0,
  input  logic             in1,
  output logic             a_valid,
  input  logic             a_ready,
  output logic             out0,
  output logic             out1,
  output logic             b_valid,
  input  logic             b_ready,
  output logic             out2,
  output logic             out3,
  output logic             sel_err,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic             sel_a;
  logic             sel_b;
  logic             sel_x;
  logic             full_a;
  logic             full_b;
  logic             push_a;
  logic             push_b;
  logic             drop;
  logic [1:0]       dout_a;
  logic [1:0]       dout_b;
  logic [CNT_W-1:0] a_cnt_q;
  logic [CNT_W-1:0] a_cnt_d;
  logic [CNT_W-1:0] b_cnt_q;
  logic [CNT_W-1:0] b_cnt_d;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;
  logic             sel_err_q;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  // Case matching is exact, so an X/Z select lands in default.
  // Hardware never sees that branch; it only exists in 4-state sim.
  always_comb begin
    sel_a = 1'b0;
    sel_b = 1'b0;
    sel_x = 1'b0;
    case (s0)
      1'b0:    sel_a = 1'b1;
      1'b1:    sel_b = 1'b1;
      default: sel_x = 1'b1;
    endcase
  end

  // A full port refuses even when it pops in the same cycle.
  assign in_ready = sel_x
                  | (sel_a & ~full_a)
                  | (sel_b & ~full_b);

  assign push_a = in_valid & sel_a & ~full_a;
  assign push_b = in_valid & sel_b & ~full_b;
  assign drop   = in_valid & sel_x;

  demux2to4_seq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push_a),
    .din_i  ({in1, in0}),
    .rdy_i  (a_ready),
    .vld_o  (a_valid),
    .dout_o (dout_a),
    .full_o (full_a)
  );

  demux2to4_seq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push_b),
    .din_i  ({in1, in0}),
    .rdy_i  (b_ready),
    .vld_o  (b_valid),
    .dout_o (dout_b),
    .full_o (full_b)
  );

  assign {out1, out0} = dout_a;
  assign {out3, out2} = dout_b;

  always_comb begin
    a_cnt_d   = a_cnt_q;
    b_cnt_d   = b_cnt_q;
    err_cnt_d = err_cnt_q;
    if (push_a) a_cnt_d   = sat_inc(a_cnt_q);
    if (push_b) b_cnt_d   = sat_inc(b_cnt_q);
    if (drop)   err_cnt_d = sat_inc(err_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
      err_cnt_q <= '0;
      sel_err_q <= 1'b0;
    end else begin
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
      err_cnt_q <= err_cnt_d;
      sel_err_q <= drop;
    end
  end

  assign a_cnt   = a_cnt_q;
  assign b_cnt   = b_cnt_q;
  assign err_cnt = err_cnt_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_demux2to4_seq.sv
// tb_demux2to4_seq: directed scenarios plus random traffic checked
// every cycle against a queue-based model of demux2to4_seq.

module tb_demux2to4_seq;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic s0 = 1'b0;
  logic in0 = 1'b0;
  logic in1 = 1'b0;
  logic a_ready = 1'b0;
  logic b_ready = 1'b0;
  logic in_ready;
  logic a_valid, b_valid;
  logic out0, out1, out2, out3;
  logic sel_err;
  logic [CNT_W-1:0] a_cnt, b_cnt, err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  bit x_ok    = 1'b0;

  logic [1:0] qa[$];
  logic [1:0] qb[$];
  logic [1:0] m_lasta = 2'b00;
  logic [1:0] m_lastb = 2'b00;
  int m_acnt = 0;
  int m_bcnt = 0;
  int m_ecnt = 0;
  logic m_err = 1'b0;

  demux2to4_seq #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s0       (s0),
    .in0      (in0),
    .in1      (in1),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .out0     (out0),
    .out1     (out1),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .out2     (out2),
    .out3     (out3),
    .sel_err  (sel_err),
    .a_cnt    (a_cnt),
    .b_cnt    (b_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic m_ready();
    if ($isunknown(s0)) return 1'b1;
    if (s0 == 1'b0) return qa.size() < DEPTH;
    return qb.size() < DEPTH;
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      m_lasta <= 2'b00;
      m_lastb <= 2'b00;
      m_acnt  <= 0;
      m_bcnt  <= 0;
      m_ecnt  <= 0;
      m_err   <= 1'b0;
    end else begin
      logic acc, xs;
      acc = in_valid && m_ready();
      xs  = $isunknown(s0);
      if (qa.size() != 0 && a_ready) begin
        m_lasta <= qa[0];
        void'(qa.pop_front());
      end
      if (qb.size() != 0 && b_ready) begin
        m_lastb <= qb[0];
        void'(qb.pop_front());
      end
      m_err <= acc && xs;
      if (acc && xs) begin
        m_ecnt <= sat(m_ecnt);
      end else if (acc && s0 == 1'b0) begin
        qa.push_back({in1, in0});
        m_acnt <= sat(m_acnt);
      end else if (acc) begin
        qb.push_back({in1, in0});
        m_bcnt <= sat(m_bcnt);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("in_ready", in_ready, m_ready());
      chk("a_valid", a_valid, qa.size() != 0);
      chk("b_valid", b_valid, qb.size() != 0);
      chk("portA", {out1, out0}, qa.size() ? qa[0] : m_lasta);
      chk("portB", {out3, out2}, qb.size() ? qb[0] : m_lastb);
      chk("sel_err", sel_err, m_err);
      chk("a_cnt", a_cnt, m_acnt);
      chk("b_cnt", b_cnt, m_bcnt);
      chk("err_cnt", err_cnt, m_ecnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_outs", {out3, out2, out1, out0}, 0);
    chk("rst_cnts", {a_cnt, b_cnt, err_cnt}, 0);

    // 1: single word to A
    tick();
    in_valid = 1; s0 = 0; in0 = 1; in1 = 0;
    tick();
    in_valid = 0;
    @(negedge clk);
    chk("t1_a_valid", a_valid, 1);
    chk("t1_out10", {out1, out0}, 2'b01);
    chk("t1_b_valid", b_valid, 0);
    chk("t1_a_cnt", a_cnt, 1);

    // 2: fill A, third word refused, B still open
    in_valid = 1; s0 = 0; in0 = 0; in1 = 1;
    tick();
    @(negedge clk);
    chk("t2_full_rdy", in_ready, 0);
    chk("t2_a_cnt", a_cnt, 2);
    s0 = 1;
    #1;
    chk("t2_b_rdy", in_ready, 1);
    tick();
    in_valid = 0;
    @(negedge clk);
    chk("t2_b_valid", b_valid, 1);

    // 3: ordered pair through B
    b_ready = 1;
    tick(); tick();
    in_valid = 1; s0 = 1; in0 = 1; in1 = 1;
    tick();
    in0 = 0; in1 = 1;
    @(negedge clk);
    chk("t3_w1", {b_valid, out3, out2}, 3'b111);
    tick();
    in_valid = 0;
    @(negedge clk);
    chk("t3_w2", {b_valid, out3, out2}, 3'b110);
    tick();
    @(negedge clk);
    chk("t3_empty", {b_valid, out3, out2}, 3'b010);

    a_ready = 1;
    repeat (3) tick();
    a_ready = 0;

    // 4: unknown select is dropped
    in_valid = 1; s0 = 1'bx;
    #1;
    x_ok = $isunknown(s0);
    if (x_ok) chk("t4_rdy", in_ready, 1);
    tick();
    in_valid = 0; s0 = 0;
    @(negedge clk);
    if (x_ok) begin
      chk("t4_sel_err", sel_err, 1);
      chk("t4_err_cnt", err_cnt, 1);
      chk("t4_valids", {a_valid, b_valid}, 0);
    end
    tick();
    @(negedge clk);
    if (x_ok) chk("t4_pulse", sel_err, 0);

    // 5: saturate a_cnt
    tick();
    a_ready = 1; s0 = 0; in_valid = 1;
    for (int i = 0; i < 300; i++) begin
      in0 = $urandom_range(0, 1);
      in1 = $urandom_range(0, 1);
      tick();
    end
    in_valid = 0;
    @(negedge clk);
    chk("t5_a_sat", a_cnt, CMAX);

    // 6: async reset with A full and B holding a word
    tick();
    a_ready = 0; b_ready = 0; in_valid = 1; s0 = 0;
    in0 = 1; in1 = 0;
    tick(); tick();
    s0 = 1;
    tick();
    in_valid = 0;
    @(negedge clk);
    chk("t6_pre", {a_valid, b_valid}, 2'b11);
    #2 rst_n = 0;
    #1;
    chk("t6_valids", {a_valid, b_valid, sel_err}, 0);
    chk("t6_outs", {out3, out2, out1, out0}, 0);
    chk("t6_cnts", {a_cnt, b_cnt, err_cnt}, 0);
    rst_n = 1;
    tick();
    in_valid = 1; s0 = 0; in0 = 1; in1 = 1;
    tick();
    in_valid = 0;
    @(negedge clk);
    chk("t6_post", {a_valid, out1, out0, b_valid}, 4'b1110);
    chk("t6_post_cnt", a_cnt, 1);
    a_ready = 1;
    tick();
    @(negedge clk);
    chk("t6_no_replay", a_valid, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      in_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) s0 = 1'bx;
      else s0 = $urandom_range(0, 1);
      in0 = $urandom_range(0, 1);
      in1 = $urandom_range(0, 1);
      a_ready = ($urandom_range(0, 4) < 3);
      b_ready = ($urandom_range(0, 4) < 2);
    end
    tick();
    in_valid = 0;
    repeat (2) @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
